// File: rtl/gcn_argmax_stage.sv
// Sequential argmax stage: accepts one node row per handshake, scans one column per cycle,
// stores the winning class index per node. Define GCN_ARGMAX_SIGNED_EN for a signed compare.
module gcn_argmax_stage #(
    parameter int FEATURE_ROWS          = 6,
    parameter int WEIGHT_COLS           = 3,
    parameter int DOT_PROD_WIDTH        = 16,
    parameter int MAX_ADDRESS_WIDTH     = 2,
    parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS)
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic                                                 start,
    input  logic                                                 row_valid,
    input  logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0]           row_data,
    output logic                                                 row_ready,
    output logic [COUNTER_FEATURE_WIDTH-1:0]                     row_index,
    output logic                                                 busy,
    output logic                                                 done_argmax,
    output logic [0:FEATURE_ROWS-1][MAX_ADDRESS_WIDTH-1:0]       max_addi_answer,
    output logic [2:0]                                           state_dbg
);

    localparam int COL_W = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(WEIGHT_COLS - 1);
    localparam logic [COUNTER_FEATURE_WIDTH-1:0] LAST_ROW = COUNTER_FEATURE_WIDTH'(FEATURE_ROWS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SCAN  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Handshake: a row transfers on a rising edge where row_valid && row_ready are both high;
    // the producer holds row_valid and row_data stable until then.

    state_t                                     state, next_state;
    logic                                       start_q;
    logic                                       start_pulse;
    logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0] captured;
    logic [DOT_PROD_WIDTH-1:0]                  best_val;
    logic [DOT_PROD_WIDTH-1:0]                  cand_val;
    logic [MAX_ADDRESS_WIDTH-1:0]               best_idx;
    logic [COL_W-1:0]                           col_ptr;
    logic                                       is_greater;

    assign start_pulse = start & ~start_q;
    assign cand_val    = captured[col_ptr];

`ifdef GCN_ARGMAX_SIGNED_EN
    assign is_greater = $signed(cand_val) > $signed(best_val);
`else
    assign is_greater = cand_val > best_val;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        row_ready   = 1'b0;
        busy        = 1'b0;
        done_argmax = 1'b0;
        case (state)
            IDLE: begin
                if (start_pulse) next_state = LOAD;
            end
            LOAD: begin
                row_ready = 1'b1;
                busy      = 1'b1;
                if (row_valid) next_state = (WEIGHT_COLS == 1) ? WRITE : SCAN;
            end
            SCAN: begin
                busy = 1'b1;
                if (col_ptr == LAST_COL) next_state = WRITE;
            end
            WRITE: begin
                busy       = 1'b1;
                next_state = (row_index == LAST_ROW) ? DONE : LOAD;
            end
            DONE: begin
                done_argmax = 1'b1;
                if (start_pulse) next_state = LOAD;
            end
            default: next_state = IDLE;
        endcase
    end

    assign state_dbg = state;

    // start_q resets high so a start held through reset release is not seen as an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_q         <= 1'b1;
            captured        <= '0;
            best_val        <= '0;
            best_idx        <= '0;
            col_ptr         <= '0;
            row_index       <= '0;
            max_addi_answer <= '0;
        end else begin
            start_q <= start;
            case (state)
                IDLE, DONE: begin
                    if (start_pulse) begin
                        max_addi_answer <= '0;
                        row_index       <= '0;
                    end
                end
                LOAD: begin
                    if (row_valid) begin
                        captured <= row_data;
                        best_val <= row_data[0];
                        best_idx <= '0;
                        col_ptr  <= COL_W'(1);
                    end
                end
                SCAN: begin
                    if (is_greater) begin
                        best_val <= cand_val;
                        best_idx <= MAX_ADDRESS_WIDTH'(col_ptr);
                    end
                    col_ptr <= col_ptr + COL_W'(1);
                end
                WRITE: begin
                    max_addi_answer[row_index] <= best_idx;
                    if (row_index != LAST_ROW) row_index <= row_index + COUNTER_FEATURE_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gcn_argmax_stage.sv
// Directed bench for gcn_argmax_stage: table-driven rows plus hand-written sequences for
// ties/backpressure, start while busy, restart from DONE and asynchronous reset mid-run.
module tb_gcn_argmax_stage;

  localparam int FR = 6;
  localparam int WC = 3;
  localparam int DW = 16;
  localparam int AW = 2;
  localparam int CW = 3;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;

`ifdef GCN_ARGMAX_SIGNED_EN
  localparam logic [AW-1:0] SGN_ANS = 2'd1;
`else
  localparam logic [AW-1:0] SGN_ANS = 2'd0;
`endif

  typedef struct {
    logic [DW-1:0] c0;
    logic [DW-1:0] c1;
    logic [DW-1:0] c2;
    logic [AW-1:0] ans;
  } vec_t;

  logic                           clk = 1'b0;
  logic                           reset;
  logic                           start;
  logic                           row_valid;
  logic [0:WC-1][DW-1:0]          row_data;
  logic                           row_ready;
  logic [CW-1:0]                  row_index;
  logic                           busy;
  logic                           done_argmax;
  logic [0:FR-1][AW-1:0]          max_addi_answer;
  logic [2:0]                     state_dbg;

  gcn_argmax_stage dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .row_valid       (row_valid),
    .row_data        (row_data),
    .row_ready       (row_ready),
    .row_index       (row_index),
    .busy            (busy),
    .done_argmax     (done_argmax),
    .max_addi_answer (max_addi_answer),
    .state_dbg       (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  vec_t basic[FR];
  vec_t ties[FR];
  int   acc[FR];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents a row and returns at the negedge just before the accepting edge.
  task automatic feed_row(input vec_t v, input int exp_idx, output int acc_cyc);
    int n;
    n = 0;
    @(negedge clk);
    row_valid = 1'b1;
    row_data  = {v.c0, v.c1, v.c2};
    while (!row_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("row_ready_seen", 32'(row_ready), 32'd1);
    check($sformatf("row_index_r%0d", exp_idx), 32'(row_index), 32'(exp_idx));
    acc_cyc = cyc + 1;
  endtask

  task automatic wait_done(output int t);
    int n;
    n = 0;
    while (!done_argmax && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(done_argmax), 32'd1);
    t = cyc;
  endtask

  task automatic check_results(input string tag, input vec_t tbl[FR]);
    for (int i = 0; i < FR; i++)
      check($sformatf("%s_ans%0d", tag, i), 32'(max_addi_answer[i]), 32'(tbl[i].ans));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_done"},    32'(done_argmax),     32'd0);
    check({tag, "_results"}, 32'(max_addi_answer), 32'd0);
    check({tag, "_busy"},    32'(busy),            32'd1);
    check({tag, "_row_idx"}, 32'(row_index),       32'd0);
  endtask

  // Feeds a full table with row_valid held high, then checks completion timing and results.
  task automatic full_run(input string tag, input vec_t tbl[FR]);
    int t;
    for (int i = 0; i < FR; i++) feed_row(tbl[i], i, acc[i]);
    wait_done(t);
    row_valid = 1'b0;
    check({tag, "_done_lat"}, 32'(t - acc[FR-1]), 32'd3);
    check_results(tag, tbl);
  endtask

  initial begin
    int t;
    vec_t rev[FR];

    basic[0] = '{16'd5, 16'd9, 16'd2, 2'd1};
    basic[1] = '{16'd8, 16'd1, 16'd3, 2'd0};
    basic[2] = '{16'd0, 16'd0, 16'd7, 2'd2};
    basic[3] = '{16'd4, 16'd4, 16'd4, 2'd0};
    basic[4] = '{16'd1, 16'd2, 16'd3, 2'd2};
    basic[5] = '{16'd9, 16'd0, 16'd0, 2'd0};

    ties[0] = '{16'd7,    16'd7,    16'd3,    2'd0};
    ties[1] = '{16'd2,    16'd6,    16'd6,    2'd1};
    ties[2] = '{16'hFFFF, 16'h0001, 16'h0000, SGN_ANS};
    ties[3] = '{16'd3,    16'd2,    16'd1,    2'd0};
    ties[4] = '{16'd1,    16'd3,    16'd2,    2'd1};
    ties[5] = '{16'd0,    16'd1,    16'd5,    2'd2};

    for (int i = 0; i < FR; i++) rev[i] = basic[FR-1-i];

    reset     = 1'b0;
    start     = 1'b0;
    row_valid = 1'b0;
    row_data  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_row_ready", 32'(row_ready),       32'd0);
    check("rst_busy",      32'(busy),            32'd0);
    check("rst_done",      32'(done_argmax),     32'd0);
    check("rst_row_index", 32'(row_index),       32'd0);
    check("rst_results",   32'(max_addi_answer), 32'd0);
    check("rst_state",     32'(state_dbg),       32'(ST_IDLE));
    reset = 1'b1;

    // Basic run with 4-cycle accept spacing
    pulse_start();
    check("basic_busy", 32'(busy), 32'd1);
    full_run("basic", basic);
    for (int i = 1; i < FR; i++)
      check($sformatf("basic_spacing%0d", i), 32'(acc[i] - acc[i-1]), 32'd4);
    check("basic_idx_sat", 32'(row_index), 32'(FR - 1));
    check("basic_idle_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("basic_hold", 32'(max_addi_answer), 32'({2'd1, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0}));

    // Ties, sign handling and a 5-cycle valid gap in LOAD
    pulse_start();
    check_cleared("ties_clr");
    feed_row(ties[0], 0, acc[0]);
    feed_row(ties[1], 1, acc[1]);
    @(negedge clk);
    row_valid = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("gap_state%0d", k), 32'(state_dbg), 32'(ST_LOAD));
      @(negedge clk);
    end
    check("gap_results", 32'(max_addi_answer), 32'({2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0}));
    check("gap_row_index", 32'(row_index), 32'd2);
    for (int i = 2; i < FR; i++) feed_row(ties[i], i, acc[i]);
    wait_done(t);
    row_valid = 1'b0;
    check_results("ties", ties);

    // Start edge while busy is ignored
    pulse_start();
    for (int i = 0; i < 3; i++) feed_row(basic[i], i, acc[i]);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_state", 32'(busy), 32'd1);
    for (int i = 3; i < FR; i++) feed_row(basic[i], i, acc[i]);
    wait_done(t);
    row_valid = 1'b0;
    check("busy_start_lat", 32'(t - acc[FR-1]), 32'd3);
    check_results("busy_start", basic);

    // Restart from DONE with reversed rows
    pulse_start();
    check_cleared("restart_clr");
    full_run("restart", rev);

    // Asynchronous reset during SCAN of row 2, start held high through release
    pulse_start();
    for (int i = 0; i < 3; i++) feed_row(basic[i], i, acc[i]);
    @(negedge clk);
    row_valid = 1'b0;
    #2;
    reset = 1'b0;
    start = 1'b1;
    #1;
    check("mid_rst_ready",   32'(row_ready),       32'd0);
    check("mid_rst_busy",    32'(busy),            32'd0);
    check("mid_rst_done",    32'(done_argmax),     32'd0);
    check("mid_rst_idx",     32'(row_index),       32'd0);
    check("mid_rst_results", 32'(max_addi_answer), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("held_start_state", 32'(state_dbg), 32'(ST_IDLE));
    check("held_start_busy",  32'(busy),      32'd0);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("toggle_start_state", 32'(state_dbg), 32'(ST_LOAD));
    full_run("post_rst", basic);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gcn_argmax_stage.md
Name: gcn_argmax_stage

Overview:
- Sequential argmax stage directly downstream of the combination stage in the GCN datapath.
- Accepts one aggregated node row at a time (FEATURE_ROWS nodes, each WEIGHT_COLS x DOT_PROD_WIDTH values) over a valid/ready handshake.
- Scans one column per cycle and writes the winning class index per node into a result array.
- Signals completion once all FEATURE_ROWS nodes are classified.

Parameters:
- FEATURE_ROWS, 6, number of graph nodes (rows) per run
- WEIGHT_COLS, 3, number of classes per row
- DOT_PROD_WIDTH, 16, width of each aggregated value
- MAX_ADDRESS_WIDTH, 2, width of a class index; must satisfy 2**MAX_ADDRESS_WIDTH >= WEIGHT_COLS
- COUNTER_FEATURE_WIDTH, $clog2(FEATURE_ROWS), width of the row counter

Ports:
- clk  in  1  rising-edge clock (single clock domain)
- reset  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  run request; rising edge starts a run
- row_valid  in  1  row_data holds a valid node row
- row_data  in  [0:WEIGHT_COLS-1][DOT_PROD_WIDTH]  aggregated values for one node
- row_ready  out  1  stage can accept a row this cycle
- row_index  out  COUNTER_FEATURE_WIDTH  index of the next row expected
- busy  out  1  run in progress
- done_argmax  out  1  all rows classified (level)
- max_addi_answer  out  [0:FEATURE_ROWS-1][MAX_ADDRESS_WIDTH]  class index per node

Behaviour:
- Reset (reset==0, async): state=IDLE; row_ready=0, busy=0, done_argmax=0, row_index=0; all max_addi_answer entries=0; internal regs cleared.
- start_q is a registered copy of start. start_pulse = start & ~start_q. Pulses while busy are ignored.
- IDLE state:
  - On start_pulse: clear all results, row_index=0, busy=1, go to LOAD.
- LOAD state:
  - row_ready=1.
  - On row_valid & row_ready: capture the whole row, set best_val=col0, best_idx=0, col_ptr=1, go to SCAN.
  - row_valid without row_ready has no effect; the row must be held by the producer.
- SCAN state:
  - row_ready=0.
  - Each cycle compare captured[col_ptr] against best_val. If strictly greater, update best_val and best_idx.
  - Increment col_ptr. After the compare at col_ptr==WEIGHT_COLS-1, go to WRITE.
  - If WEIGHT_COLS==1, go directly from LOAD to WRITE.
- WRITE state:
  - max_addi_answer[row_index] <= best_idx.
  - If row_index==FEATURE_ROWS-1: go to DONE. Otherwise increment row_index and return to LOAD.
- DONE state:
  - busy=0, done_argmax=1, results held stable.
  - A new start_pulse clears done_argmax and results on the next edge and enters LOAD.
- Timing:
  - Per-row occupancy is WEIGHT_COLS+1 cycles (accept, WEIGHT_COLS-1 scans, write). For the defaults this is 4 cycles per row.
  - The earliest next row_ready is 3 cycles after accept for the defaults.
  - done_argmax rises the cycle after the last WRITE.
- Ties: the lowest index wins (strictly-greater compare only).
- Default comparison is unsigned on the full DOT_PROD_WIDTH.
- row_index never wraps within a run. It saturates at FEATURE_ROWS-1 until DONE and resets to 0 on the next start.
- A result entry is only ever written in WRITE; partially scanned rows are never written.
- Reset mid-run discards all progress immediately. After reset release the block sits in IDLE and needs a fresh start rising edge. A start held high through reset release does not count as a rising edge, because start_q is reset to 1.

Optional Feature:
- Macro: GCN_ARGMAX_SIGNED_EN.
- Defined: values are compared as two's-complement signed DOT_PROD_WIDTH numbers.
- Undefined: unsigned compare.
- All timing and handshake behaviour is identical in both cases.

Test Plan:
- Basic run: reset, start pulse, feed 6 rows {5,9,2},{8,1,3},{0,0,7},{4,4,4},{1,2,3},{9,0,0} with row_valid held high -> answers 1,0,2,0,2,0; done_argmax rises 1 cycle after the 6th WRITE; row_ready spacing is 4 cycles.
- Ties and backpressure: rows {7,7,3} and {2,6,6} -> answers 0 and 1. Also drop row_valid for 5 cycles mid-run -> FSM stays in LOAD, no result changes, and the run resumes correctly.
- Sign handling: row {16'hFFFF,16'h0001,16'h0000} -> answer 0 without GCN_ARGMAX_SIGNED_EN; answer 1 with it.
- Start while busy: assert a start rising edge during row 3 -> ignored; results match the uninterrupted run. A new start pulse in DONE -> done_argmax drops, results clear to 0, and a second run completes correctly.
- Reset mid-run: drive reset low asynchronously during SCAN of row 2 -> all outputs read 0 immediately. After release with start held high, the block stays in IDLE until start toggles 0 then 1.
